// File: rtl/telemetry_uart_arbiter.sv
// Round-robin, frame-granular arbiter sharing one UART transmitter between N_REQ byte streams.
// Each byte is sequenced through tx_valid/tx_done; frame completion, abort and UART stalls are flagged.
module telemetry_uart_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ID_W          = 2,
  parameter int BUSY_TIMEOUT  = 16,
  parameter int FRAME_TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  input  logic [N_REQ-1:0]     req_enable,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_done,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 tx_timeout,
  output logic [15:0]          frame_count
);

  // state     | meaning
  // ----------+------------------------------------------------------------
  // IDLE      | no owner; round-robin search from rr over valid & enabled
  // SEND      | owner granted; issue its byte once UART is ready
  // WAIT_ACK  | byte pulsed; wait for tx_done to fall (or busy timeout)
  // WAIT_DONE | wait for tx_done to rise; then next byte or end of frame
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE} state_t;

  localparam int BT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr, rr_nxt;
  logic [ID_W-1:0]   gid_nxt;
  logic              gv_nxt;
  logic [7:0]        txd_nxt;
  logic              txv_nxt;
  logic [N_REQ-1:0]  rdy_nxt;
  logic              last_flag, last_nxt;
  logic              fd_nxt, fa_nxt, to_nxt;
  logic [15:0]       fc_nxt;
  logic [FT_W-1:0]   idle_cnt, idle_nxt;
  logic [BT_W-1:0]   busy_cnt, busy_nxt;

  logic [N_REQ-1:0]  cand;
  logic              hit;
  logic [ID_W-1:0]   pick;
  logic [ID_W:0]     sum;
  logic              own_valid, own_last;
  logic [7:0]        own_data;
  logic [N_REQ-1:0]  owner_oh;
  logic [ID_W-1:0]   rr_after;

  assign cand      = req_valid & req_enable;
  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign own_data  = req_data[{grant_id, 3'b000} +: 8];
  assign owner_oh  = N_REQ'(1) << grant_id;
  assign rr_after  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // First candidate at or after rr, wrapping modulo N_REQ.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      if (!hit && cand[sum[ID_W-1:0]]) begin
        hit  = 1'b1;
        pick = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    gid_nxt   = grant_id;
    gv_nxt    = grant_valid;
    txd_nxt   = tx_data;
    last_nxt  = last_flag;
    fc_nxt    = frame_count;
    idle_nxt  = idle_cnt;
    busy_nxt  = busy_cnt;
    txv_nxt   = 1'b0;
    rdy_nxt   = '0;
    fd_nxt    = 1'b0;
    fa_nxt    = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          gid_nxt   = pick;
          gv_nxt    = 1'b1;
          idle_nxt  = FT_W'(FRAME_TIMEOUT);
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (own_valid) begin
          idle_nxt = FT_W'(FRAME_TIMEOUT);
          if (tx_done) begin
            txd_nxt   = own_data;
            last_nxt  = own_last;
            txv_nxt   = 1'b1;
            rdy_nxt   = owner_oh;
            busy_nxt  = BT_W'(BUSY_TIMEOUT);
            state_nxt = S_WAIT_ACK;
          end
        end else if (idle_cnt <= FT_W'(1)) begin
          fa_nxt    = 1'b1;
          gv_nxt    = 1'b0;
          rr_nxt    = rr_after;
          state_nxt = S_IDLE;
        end else begin
          idle_nxt = idle_cnt - FT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (!tx_done) begin
          state_nxt = S_WAIT_DONE;
        end else if (busy_cnt <= BT_W'(1)) begin
          to_nxt    = 1'b1;
          state_nxt = S_WAIT_DONE;
        end else begin
          busy_nxt = busy_cnt - BT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          if (last_flag) begin
            fd_nxt    = 1'b1;
            fc_nxt    = frame_count + 16'd1;
            gv_nxt    = 1'b0;
            rr_nxt    = rr_after;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_SEND;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rr          <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      req_ready   <= '0;
      last_flag   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      tx_timeout  <= 1'b0;
      frame_count <= '0;
      idle_cnt    <= '0;
      busy_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      rr          <= rr_nxt;
      grant_id    <= gid_nxt;
      grant_valid <= gv_nxt;
      tx_data     <= txd_nxt;
      tx_valid    <= txv_nxt;
      req_ready   <= rdy_nxt;
      last_flag   <= last_nxt;
      frame_done  <= fd_nxt;
      frame_abort <= fa_nxt;
      tx_timeout  <= to_nxt;
      frame_count <= fc_nxt;
      idle_cnt    <= idle_nxt;
      busy_cnt    <= busy_nxt;
    end
  end

endmodule

// File: doc/telemetry_uart_arbiter.md
Name: telemetry_uart_arbiter

Overview:
Shares the single UART transmitter between N_REQ byte-stream requesters, typically per-channel ASCII formatters (accel, gyro, baro, status). Arbitration is round-robin at frame granularity. A granted requester owns the UART until its byte flagged `req_last` has been transmitted. The block sequences every byte through the UART's `tx_valid`/`tx_done` handshake and reports frame statistics and fault events.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must equal clog2(N_REQ)
- BUSY_TIMEOUT, 16, max cycles to wait for tx_done to fall after a tx_valid pulse
- FRAME_TIMEOUT, 50000, max consecutive cycles the granted requester may hold req_valid low mid-frame

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i]
- req_last  in  N_REQ  current byte is the frame's final byte
- req_enable  in  N_REQ  requester may win arbitration
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i consumed
- tx_done  in  1  UART idle/ready (high = may accept a byte)
- tx_data  out  8  byte to UART
- tx_valid  out  1  one-cycle start pulse to UART
- grant_valid  out  1  a requester currently owns the UART
- grant_id  out  ID_W  index of the owner
- frame_done  out  1  one-cycle pulse: frame completed normally
- frame_abort  out  1  one-cycle pulse: frame released by FRAME_TIMEOUT
- tx_timeout  out  1  one-cycle pulse: BUSY_TIMEOUT expired
- frame_count  out  16  completed-frame counter, wraps 0xFFFF->0

Behaviour:
- All outputs registered. Reset (sync, high) values:
  - req_ready=0, tx_data=0, tx_valid=0, grant_valid=0, grant_id=0
  - frame_done=0, frame_abort=0, tx_timeout=0, frame_count=0
  - rr pointer=0, state=IDLE
- Reset asserted mid-operation takes effect at the next edge. No byte is completed and no pulse is emitted.
- State IDLE:
  - Search candidates = req_valid & req_enable, starting at rr pointer, ascending with wrap.
  - On a hit, latch grant_id and set grant_valid=1 the next cycle, then go to SEND.
  - No candidates: stay in IDLE.
- State SEND:
  - If tx_done=1 and req_valid[g]=1:
    - Register tx_data=req_data[g] and last_flag=req_last[g].
    - Pulse tx_valid=1 and req_ready[g]=1 together next cycle, then go to WAIT_ACK.
  - The requester holds data/last stable until it sees req_ready. It may present its next byte in the cycle after req_ready.
  - If req_valid[g]=0, the idle counter increments. Once it reaches FRAME_TIMEOUT:
    - Pulse frame_abort, clear grant_valid, set rr=g+1 mod N_REQ, go to IDLE.
  - The idle counter clears whenever a byte is issued.
- State WAIT_ACK:
  - Wait for tx_done=0 (UART took the byte), then go to WAIT_DONE.
  - If BUSY_TIMEOUT cycles elapse with tx_done still 1, pulse tx_timeout and proceed as if acknowledged.
- State WAIT_DONE:
  - Wait for tx_done=1.
  - If last_flag=0: go to SEND.
  - If last_flag=1:
    - Pulse frame_done and increment frame_count.
    - Clear grant_valid, set rr=g+1 mod N_REQ, go to IDLE.
- Exactly one tx_valid pulse per accepted byte. tx_valid is never asserted outside the cycle after SEND.
- Minimum byte spacing is 4 cycles: SEND, pulse, WAIT_ACK, WAIT_DONE.
- Simultaneous requests in IDLE: lowest index at or after rr wins.
- A requester that drops out never blocks others beyond FRAME_TIMEOUT.
- req_enable changes are sampled only in IDLE. Deasserting the owner's enable mid-frame does not abort the frame.
- Owner with req_valid and req_last both high on its first byte gives a 1-byte frame, which is legal.
- frame_done and frame_abort are never asserted in the same cycle.
- Unused states decode to IDLE.

Test Plan:
- Single requester: req 0 sends "123 |" (0x31,0x32,0x33,0x20,0x7C, last on 0x7C); UART model drops tx_done 1 cycle after tx_valid for 10 cycles -> tx_data sequence matches, 5 tx_valid pulses, 5 req_ready[0] pulses, one frame_done, frame_count=1.
- Contention: req 0..3 all valid at once, each sending a 2-byte frame -> grants in order 0,1,2,3. Then req 0 and 2 request again -> grant 0 then 2; frames never interleave.
- Fairness: req 1 continuously re-requests while req 3 waits -> grant alternates 1,3,1,3. req_enable[3]=0 -> only 1 is granted.
- Stalled requester: req 2 sends 1 byte (last=0) then drops req_valid -> after FRAME_TIMEOUT cycles, frame_abort pulse, grant_valid=0, pending req 3 granted next, frame_count unchanged.
- UART not responding: tx_done held at 1 after tx_valid -> tx_timeout pulse after BUSY_TIMEOUT cycles, next byte still issued. tx_done held at 0 -> no further tx_valid.
- Reset mid-frame at byte 3 of 5 -> all outputs at reset values the next cycle. Post-reset, rr=0 and a new frame from req 0 completes normally.
